// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Bit-counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Two's-complement negate on a 64-bit container; callers size-cast the result.
    function automatic logic [63:0] twos_neg(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Conditional absolute value: returns |val| when en is set and val is negative.
// The most-negative input maps to its unsigned magnitude 2^(W-1).
module twos_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         en,
    output logic [W-1:0] mag,
    output logic         is_neg
);

    // Negate only when the operand is treated as signed and its MSB is set.
    always_comb begin
        is_neg = en & val[W-1];
        mag    = is_neg ? (~val + W'(1)) : val;
    end

endmodule

// File: rtl/rtl_multiply_n.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier magnitude is zero instead of always running WIDTH cycles.
module rtl_multiply_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_a, neg_b;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mb_shift;
    logic                 last_step;

    twos_abs #(.W(WIDTH)) u_abs_a (
        .val    (multiplicand),
        .en     (signed_op),
        .mag    (mag_a),
        .is_neg (neg_a)
    );

    twos_abs #(.W(WIDTH)) u_abs_b (
        .val    (multiplier),
        .en     (signed_op),
        .mag    (mag_b),
        .is_neg (neg_b)
    );

    // Datapath for one CALC step and the finish condition.
    always_comb begin
        acc_sum   = acc_q + (mb_q[0] ? mc_q : '0);
        mb_shift  = mb_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
        last_step = (cnt_q == LAST_CNT) || (mb_shift == '0);
`else
        last_step = (cnt_q == LAST_CNT);
`endif
    end

    // Next-state and register updates for the IDLE/CALC controller.
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mc_d    = {{WIDTH{1'b0}}, mag_a};
                    mb_d    = mag_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sign_d  = neg_a ^ neg_b;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                mc_d  = mc_q << 1;
                mb_d  = mb_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    product_d = sign_q ? (2*WIDTH)'(twos_neg(64'(acc_sum))) : acc_sum;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mc_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == CALC);
    assign done    = done_q;

endmodule

// File: tb/tb_rtl_multiply_n.sv
// Directed bench for rtl_multiply_n at WIDTH=4 and WIDTH=8.
module tb_rtl_multiply_n;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       start4 = 1'b0, s4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] product4;
    logic       busy4, done4;

    logic       start8 = 1'b0, s8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] product8;
    logic       busy8, done8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rtl_multiply_n #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .signed_op(s4),
        .multiplicand(a4), .multiplier(b4),
        .product(product4), .busy(busy4), .done(done4)
    );

    rtl_multiply_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .signed_op(s8),
        .multiplicand(a8), .multiplier(b8),
        .product(product8), .busy(busy8), .done(done8)
    );

    // Expected latency from the multiplier magnitude.
    function automatic int exp_lat(input int mag_b, input int w);
`ifdef MULT_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < w; i++) if (((mag_b >> i) & 1) != 0) hi = i + 1;
        return (hi < 1) ? 1 : hi;
`else
        return w;
`endif
    endfunction

    // Issue one WIDTH=4 operation; lat = edges from capture to done (-1 on timeout).
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output logic [7:0] p, output int lat);
        @(negedge clk);
        a4 = a; b4 = b; s4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = k;
                break;
            end
        end
        p = product4;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        p = product8;
    endtask

    task automatic test_reset();
        total++; if (product4 !== 8'h00) begin bad++; $display("FAIL reset_product4 got=%h want=00", product4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", busy4); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done4 got=%b want=0", done4); end
        total++; if (product8 !== 16'h0000) begin bad++; $display("FAIL reset_product8 got=%h want=0000", product8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b want=0", done8); end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] p;
        int         mag_b;
    } vec4_t;

    task automatic test_width4();
        vec4_t v[8];
        logic [7:0] p;
        int lat;
        v[0] = '{4'd4,  4'd3,  1'b0, 8'd12,  3};
        v[1] = '{4'd7,  4'd9,  1'b0, 8'd63,  9};
        v[2] = '{4'd15, 4'd15, 1'b0, 8'hE1,  15};
        v[3] = '{4'd0,  4'd13, 1'b0, 8'd0,   13};
        v[4] = '{4'hD,  4'd5,  1'b1, 8'hF1,  5};
        v[5] = '{4'h8,  4'h8,  1'b1, 8'h40,  8};
        v[6] = '{4'h8,  4'h7,  1'b1, 8'hC8,  7};
        v[7] = '{4'hF,  4'h1,  1'b0, 8'd15,  1};
        for (int i = 0; i < 8; i++) begin
            run4(v[i].a, v[i].b, v[i].s, p, lat);
            total++;
            if (p !== v[i].p) begin
                bad++;
                $display("FAIL w4_product[%0d] %h*%h s=%b got=%h want=%h", i, v[i].a, v[i].b, v[i].s, p, v[i].p);
            end
            total++;
            if (lat != exp_lat(v[i].mag_b, 4)) begin
                bad++;
                $display("FAIL w4_latency[%0d] got=%0d want=%0d", i, lat, exp_lat(v[i].mag_b, 4));
            end
            total++;
            if (busy4 !== 1'b0) begin bad++; $display("FAIL w4_busy_at_done[%0d] got=%b want=0", i, busy4); end
        end
        // 0 * 13 with 13 as multiplicand: |B|=0 case
        run4(4'd13, 4'd0, 1'b0, p, lat);
        total++; if (p !== 8'd0) begin bad++; $display("FAIL w4_zero_b got=%h want=00", p); end
        total++; if (lat != exp_lat(0, 4)) begin bad++; $display("FAIL w4_zero_b_latency got=%0d want=%0d", lat, exp_lat(0, 4)); end
    endtask

    task automatic test_width8();
        logic [15:0] p;
        int lat;
        run8(8'h80, 8'h80, 1'b1, p, lat);
        total++; if (p !== 16'h4000) begin bad++; $display("FAIL w8_signed_min got=%h want=4000", p); end
        total++; if (lat != exp_lat(128, 8)) begin bad++; $display("FAIL w8_signed_min_latency got=%0d want=%0d", lat, exp_lat(128, 8)); end
        run8(8'hFF, 8'hFF, 1'b0, p, lat);
        total++; if (p !== 16'hFE01) begin bad++; $display("FAIL w8_unsigned_max got=%h want=fe01", p); end
        total++; if (lat != 8) begin bad++; $display("FAIL w8_unsigned_max_latency got=%0d want=8", lat); end
    endtask

    task automatic test_start_held();
        int dones;
        int lat;
        dones = 0;
        lat = -1;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd5; s4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL held_busy_after_capture got=%b want=1", busy4); end
        a4 = 4'd3; b4 = 4'd2;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done4) begin
                dones++;
                lat = k;
                start4 = 1'b0;
                break;
            end
        end
        total++; if (product4 !== 8'd25) begin bad++; $display("FAIL held_product got=%h want=19", product4); end
        total++; if (lat != exp_lat(5, 4)) begin bad++; $display("FAIL held_latency got=%0d want=%0d", lat, exp_lat(5, 4)); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL held_done_count got=%0d want=1", dones); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL held_idle_after got=%b want=0", busy4); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        int lat;
        run4(4'd4, 4'd3, 1'b0, p, lat);
        total++; if (p !== 8'd12) begin bad++; $display("FAIL b2b_first got=%h want=0c", p); end
        @(negedge clk);
        total++; if (done4 !== 1'b1) begin bad++; $display("FAIL b2b_in_done_cycle got=%b want=1", done4); end
        a4 = 4'd2; b4 = 4'd3; s4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL b2b_accepted got=%b want=1", busy4); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b want=0", done4); end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done4) begin lat = k; break; end
        end
        total++; if (product4 !== 8'd6) begin bad++; $display("FAIL b2b_second got=%h want=06", product4); end
        total++; if (lat != exp_lat(3, 4)) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, exp_lat(3, 4)); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] p;
        int lat;
        int dones;
        dones = 0;
        total++; if (product4 === 8'd0) begin bad++; $display("FAIL abort_precondition got=%h want=nonzero", product4); end
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd9; s4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy4); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done4); end
        total++; if (product4 !== 8'd0) begin bad++; $display("FAIL abort_product got=%h want=00", product4); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        run4(4'd6, 4'd7, 1'b0, p, lat);
        total++; if (p !== 8'd42) begin bad++; $display("FAIL abort_recover got=%h want=2a", p); end
        total++; if (lat != exp_lat(7, 4)) begin bad++; $display("FAIL abort_recover_latency got=%0d want=%0d", lat, exp_lat(7, 4)); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_width4();
        test_width8();
        test_start_held();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
